// File: rtl/crc_check.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : crc_check
// Purpose  : Receive-side CRC checker. Strips the trailing CRC from a serial
//            packet, forwards the payload and reports a one-cycle verdict.
// Revision : 1.0 - initial release
// ============================================================================
module crc_check #(
  parameter int unsigned      CRC_W    = 5,
  parameter logic [CRC_W-1:0] POLY     = 5'b00101,
  parameter logic [CRC_W-1:0] INIT     = 5'b11111,
  parameter logic [CRC_W-1:0] RESIDUAL = 5'b01100
) (
  input  logic clk,
  input  logic rst_L,
  input  logic inb,
  input  logic recving,
  input  logic pause_out,
  output logic pause_in,
  output logic outb,
  output logic sending,
  output logic crc_valid,
  output logic crc_ok
);

  localparam int unsigned      CNT_W    = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CRC_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PASS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CRC_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             w_fb;
  logic [CRC_W-1:0] w_lfsr_step;
  logic [CRC_W-1:0] w_delay_step;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_accept;

  assign w_fb         = inb ^ lfsr_q[CRC_W-1];
  assign w_lfsr_step  = (lfsr_q << 1) ^ (w_fb ? POLY : '0);
  assign w_delay_step = (delay_q << 1) | CRC_W'(inb);
  assign w_count_inc  = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= S_IDLE;
      lfsr_q  <= INIT;
      delay_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      delay_q <= delay_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    delay_d   = delay_q;
    count_d   = count_q;
    w_accept  = 1'b0;
    pause_in  = 1'b0;
    sending   = 1'b0;
    outb      = 1'b0;
    crc_valid = 1'b0;
    crc_ok    = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_accept = recving;
        if (recving) begin
          state_d = (CRC_W == 1) ? S_PASS : S_FILL;
        end
      end

      S_FILL: begin
        if (recving) begin
          w_accept = 1'b1;
          if (w_count_inc == CNT_FULL) begin
            state_d = S_PASS;
          end
        end else begin
          state_d = S_DONE;
        end
      end

      // The oldest delayed bit leaves downstream on the same cycle a new bit
      // enters, so a downstream stall must also stall the upstream source.
      S_PASS: begin
        pause_in = pause_out;
        sending  = recving;
        outb     = delay_q[CRC_W-1];
        if (recving) begin
          w_accept = !pause_out;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        crc_valid = 1'b1;
        crc_ok    = (lfsr_q == RESIDUAL) && (count_q == CNT_FULL);
        pause_in  = 1'b1;
        state_d   = S_IDLE;
        lfsr_d    = INIT;
        delay_d   = '0;
        count_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_accept) begin
      lfsr_d  = w_lfsr_step;
      delay_d = w_delay_step;
      count_d = w_count_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_crc_check
// Purpose  : Directed self-checking bench for crc_check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_check;

  logic clk;
  logic rst_L;
  logic inb;
  logic recving;
  logic pause_out;
  logic pause_in;
  logic outb;
  logic sending;
  logic crc_valid;
  logic crc_ok;

  int tests_run    = 0;
  int tests_failed = 0;

  // Sampled outputs of the most recent cycle
  logic s_outb, s_sending, s_pause_in, s_crc_valid, s_crc_ok;

  // Observations gathered by drive_packet
  int          obs_fwd_cnt;
  logic [31:0] obs_fwd_word;
  int          obs_valid_cnt;
  int          obs_valid_lat;
  logic        obs_ok;
  int          obs_pause_cnt;
  int          obs_hold_bad;
  int          obs_send_tail;
  logic        obs_timeout;

  crc_check dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .inb       (inb),
    .recving   (recving),
    .pause_out (pause_out),
    .pause_in  (pause_in),
    .outb      (outb),
    .sending   (sending),
    .crc_valid (crc_valid),
    .crc_ok    (crc_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1: drive inputs, sample at negedge, advance to next posedge+1.
  task automatic cycle(input logic b, input logic r);
    inb     = b;
    recving = r;
    @(negedge clk);
    s_outb      = outb;
    s_sending   = sending;
    s_pause_in  = pause_in;
    s_crc_valid = crc_valid;
    s_crc_ok    = crc_ok;
    @(posedge clk);
    #1;
  endtask

  // Presents pkt[0..n-1], honouring pause_in; optionally stalls downstream
  // once stall_at bits have been forwarded; then runs tail idle cycles.
  task automatic drive_packet(input logic [31:0] pkt, input int n,
                              input int stall_at, input int stall_len,
                              input int tail);
    int   idx;
    int   stalls;
    int   cyc;
    logic held;
    obs_fwd_cnt   = 0;
    obs_fwd_word  = '0;
    obs_valid_cnt = 0;
    obs_valid_lat = -1;
    obs_ok        = 1'b0;
    obs_pause_cnt = 0;
    obs_hold_bad  = 0;
    obs_send_tail = 0;
    obs_timeout   = 1'b0;
    idx    = 0;
    stalls = 0;
    cyc    = 0;
    held   = 1'b0;
    while (idx < n && cyc < 200) begin
      pause_out = (stall_at >= 0) && (obs_fwd_cnt == stall_at) && (stalls < stall_len);
      cycle(pkt[idx], 1'b1);
      if (pause_out) begin
        if (stalls == 0) held = s_outb;
        else if (s_outb !== held) obs_hold_bad++;
        if (s_pause_in) obs_pause_cnt++;
        stalls++;
      end else if (s_sending && obs_fwd_cnt < 32) begin
        obs_fwd_word[obs_fwd_cnt] = s_outb;
        obs_fwd_cnt++;
      end
      if (s_crc_valid) obs_valid_cnt++;
      if (!s_pause_in) idx++;
      cyc++;
    end
    if (cyc >= 200) obs_timeout = 1'b1;
    pause_out = 1'b0;
    for (int k = 0; k < tail; k++) begin
      cycle(1'b0, 1'b0);
      if (s_sending) obs_send_tail++;
      if (s_crc_valid) begin
        obs_valid_cnt++;
        obs_valid_lat = k;
        obs_ok        = s_crc_ok;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests_run++; if ({sending, outb, pause_in, crc_valid, crc_ok} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b expected 00000", {sending, outb, pause_in, crc_valid, crc_ok}); end
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0);
    tests_run++; if ({s_sending, s_outb, s_pause_in, s_crc_valid} !== 4'b0) begin tests_failed++; $display("FAIL idle_outputs: got %b expected 0000", {s_sending, s_outb, s_pause_in, s_crc_valid}); end
  endtask

  task automatic test_good_packet();
    drive_packet(32'h0000_1000, 16, -1, 0, 3);
    tests_run++; if (obs_timeout !== 1'b0) begin tests_failed++; $display("FAIL good_timeout: got %b expected 0", obs_timeout); end
    tests_run++; if (obs_fwd_cnt !== 11) begin tests_failed++; $display("FAIL good_fwd_cnt: got %0d expected 11", obs_fwd_cnt); end
    tests_run++; if (obs_fwd_word !== 32'h0) begin tests_failed++; $display("FAIL good_fwd_bits: got %h expected 0", obs_fwd_word); end
    tests_run++; if (obs_send_tail !== 0) begin tests_failed++; $display("FAIL good_crc_forwarded: got %0d expected 0", obs_send_tail); end
    tests_run++; if (obs_valid_cnt !== 1 || obs_valid_lat !== 1) begin tests_failed++; $display("FAIL good_valid: got cnt %0d lat %0d expected cnt 1 lat 1", obs_valid_cnt, obs_valid_lat); end
    tests_run++; if (obs_ok !== 1'b1) begin tests_failed++; $display("FAIL good_crc_ok: got %b expected 1", obs_ok); end
  endtask

  task automatic test_bad_crc();
    drive_packet(32'h0000_9000, 16, -1, 0, 3);
    tests_run++; if (obs_fwd_cnt !== 11 || obs_fwd_word !== 32'h0) begin tests_failed++; $display("FAIL bad_fwd: got cnt %0d bits %h expected 11 / 0", obs_fwd_cnt, obs_fwd_word); end
    tests_run++; if (obs_valid_cnt !== 1) begin tests_failed++; $display("FAIL bad_valid_cnt: got %0d expected 1", obs_valid_cnt); end
    tests_run++; if (obs_ok !== 1'b0) begin tests_failed++; $display("FAIL bad_crc_ok: got %b expected 0", obs_ok); end
  endtask

  task automatic test_stall();
    drive_packet(32'h0000_1000, 16, 3, 3, 3);
    tests_run++; if (obs_pause_cnt !== 3) begin tests_failed++; $display("FAIL stall_pause_in: got %0d expected 3", obs_pause_cnt); end
    tests_run++; if (obs_hold_bad !== 0) begin tests_failed++; $display("FAIL stall_outb_hold: got %0d changes expected 0", obs_hold_bad); end
    tests_run++; if (obs_fwd_cnt !== 11 || obs_fwd_word !== 32'h0) begin tests_failed++; $display("FAIL stall_fwd: got cnt %0d bits %h expected 11 / 0", obs_fwd_cnt, obs_fwd_word); end
    tests_run++; if (obs_ok !== 1'b1 || obs_valid_cnt !== 1) begin tests_failed++; $display("FAIL stall_crc_ok: got ok %b cnt %0d expected 1 / 1", obs_ok, obs_valid_cnt); end
  endtask

  // Payload 1,1,0,1,0,0,1,0,1,1,0 leaves lfsr=11111, so the CRC sent is 00000.
  task automatic test_mixed_payload();
    drive_packet(32'h0000_034B, 16, 3, 2, 3);
    tests_run++; if (obs_fwd_cnt !== 11) begin tests_failed++; $display("FAIL mixed_fwd_cnt: got %0d expected 11", obs_fwd_cnt); end
    tests_run++; if (obs_fwd_word !== 32'h0000_034B) begin tests_failed++; $display("FAIL mixed_fwd_bits: got %h expected 0000034b", obs_fwd_word); end
    tests_run++; if (obs_pause_cnt !== 2 || obs_hold_bad !== 0) begin tests_failed++; $display("FAIL mixed_stall: got pause %0d hold_bad %0d expected 2 / 0", obs_pause_cnt, obs_hold_bad); end
    tests_run++; if (obs_ok !== 1'b1) begin tests_failed++; $display("FAIL mixed_crc_ok: got %b expected 1", obs_ok); end
  endtask

  task automatic test_short_packet();
    drive_packet(32'h0000_0005, 3, -1, 0, 3);
    tests_run++; if (obs_fwd_cnt !== 0 || obs_send_tail !== 0) begin tests_failed++; $display("FAIL short_sending: got %0d/%0d expected 0/0", obs_fwd_cnt, obs_send_tail); end
    tests_run++; if (obs_valid_cnt !== 1 || obs_valid_lat !== 1) begin tests_failed++; $display("FAIL short_valid: got cnt %0d lat %0d expected 1 / 1", obs_valid_cnt, obs_valid_lat); end
    tests_run++; if (obs_ok !== 1'b0) begin tests_failed++; $display("FAIL short_crc_ok: got %b expected 0", obs_ok); end
    // Zero-length payload: the CRC of nothing is ~INIT = 00000
    drive_packet(32'h0000_0000, 5, -1, 0, 3);
    tests_run++; if (obs_fwd_cnt !== 0 || obs_send_tail !== 0) begin tests_failed++; $display("FAIL empty_sending: got %0d/%0d expected 0/0", obs_fwd_cnt, obs_send_tail); end
    tests_run++; if (obs_valid_cnt !== 1 || obs_ok !== 1'b1) begin tests_failed++; $display("FAIL empty_crc_ok: got cnt %0d ok %b expected 1 / 1", obs_valid_cnt, obs_ok); end
  endtask

  task automatic test_reset_mid_packet();
    int valids;
    drive_packet(32'h0000_1000, 8, -1, 0, 0);
    tests_run++; if (obs_fwd_cnt !== 3) begin tests_failed++; $display("FAIL midrst_pre_fwd: got %0d expected 3", obs_fwd_cnt); end
    rst_L = 1'b0;
    #1;
    tests_run++; if ({sending, outb, pause_in, crc_valid, crc_ok} !== 5'b0) begin tests_failed++; $display("FAIL midrst_outputs: got %b expected 00000", {sending, outb, pause_in, crc_valid, crc_ok}); end
    recving = 1'b0;
    valids  = 0;
    repeat (2) begin
      @(negedge clk);
      if (crc_valid) valids++;
    end
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0);
      if (s_crc_valid) valids++;
    end
    tests_run++; if (valids !== 0) begin tests_failed++; $display("FAIL midrst_no_valid: got %0d expected 0", valids); end
    drive_packet(32'h0000_1000, 16, -1, 0, 3);
    tests_run++; if (obs_fwd_cnt !== 11 || obs_ok !== 1'b1 || obs_valid_cnt !== 1) begin tests_failed++; $display("FAIL midrst_clean: got fwd %0d ok %b cnt %0d expected 11 / 1 / 1", obs_fwd_cnt, obs_ok, obs_valid_cnt); end
  endtask

  task automatic test_back_to_back();
    drive_packet(32'h0000_1000, 16, -1, 0, 1);
    tests_run++; if (obs_fwd_cnt !== 11) begin tests_failed++; $display("FAIL b2b_first_fwd: got %0d expected 11", obs_fwd_cnt); end
    // DONE cycle: second packet's first bit is offered but held
    cycle(1'b0, 1'b1);
    tests_run++; if (s_crc_valid !== 1'b1 || s_crc_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_verdict: got valid %b ok %b expected 1 / 1", s_crc_valid, s_crc_ok); end
    tests_run++; if (s_pause_in !== 1'b1) begin tests_failed++; $display("FAIL b2b_pause_in: got %b expected 1", s_pause_in); end
    drive_packet(32'h0000_1000, 16, -1, 0, 3);
    tests_run++; if (obs_fwd_cnt !== 11 || obs_fwd_word !== 32'h0) begin tests_failed++; $display("FAIL b2b_second_fwd: got cnt %0d bits %h expected 11 / 0", obs_fwd_cnt, obs_fwd_word); end
    tests_run++; if (obs_ok !== 1'b1 || obs_valid_lat !== 1) begin tests_failed++; $display("FAIL b2b_second_verdict: got ok %b lat %0d expected 1 / 1", obs_ok, obs_valid_lat); end
  endtask

  initial begin
    rst_L     = 1'b0;
    inb       = 1'b0;
    recving   = 1'b0;
    pause_out = 1'b0;
    test_reset();
    test_good_packet();
    test_bad_crc();
    test_stall();
    test_mixed_payload();
    test_short_packet();
    test_reset_mid_packet();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_check.md
Name: crc_check

Overview:
- Receive-side counterpart of the CRC append stage.
- Consumes a serial bitstream whose last CRC_W bits are the transmitted (complemented) CRC, and forwards only the payload bits downstream, delayed by CRC_W accepted bits.
- Strips the trailing CRC and raises a one-cycle CRC verdict at end of packet.
- Sits between the bit-unstuff/NRZI decode stage and the packet field parser.

Parameters:
- CRC_W, 5, CRC width (5 for tokens, 16 for data).
- POLY, 5'b00101, generator polynomial without its MSB term (x^5+x^2+1).
- INIT, 5'b11111, LFSR seed at the start of each packet.
- RESIDUAL, 5'b01100, LFSR value after payload plus a correct CRC has been shifted through.

Ports:
- clk, input, 1, system clock.
- rst_L, input, 1, asynchronous active-low reset.
- inb, input, 1, serial bit from upstream.
- recving, input, 1, upstream packet active; a bit is presented while high.
- pause_out, input, 1, downstream stall; outb must be held while high.
- pause_in, output, 1, stall to upstream; inb/recving are held by the source while high.
- outb, output, 1, forwarded payload bit.
- sending, output, 1, outb valid.
- crc_valid, output, 1, one-cycle end-of-packet strobe.
- crc_ok, output, 1, verdict; meaningful only while crc_valid=1.

Behaviour:
- Reset (rst_L=0, async): state=IDLE, lfsr=INIT, delay line=0, count=0. All outputs 0.
- Accept: a bit is accepted on a cycle when recving=1 and pause_in=0.
- LFSR step on accept: fb = inb ^ lfsr[CRC_W-1]; lfsr <= {lfsr[CRC_W-2:0],0} ^ (fb ? POLY : 0).
- Delay line: CRC_W-bit shift register. Each accept shifts inb in. outb = oldest bit.
- count: saturating counter of accepted bits, 0..CRC_W, width $clog2(CRC_W+1).
- IDLE:
  - pause_in=0; lfsr holds INIT.
  - recving=1: accept first bit (lfsr steps from INIT), count=1, go FILL. If CRC_W=1, go PASS instead.
- FILL:
  - pause_in=0, sending=0.
  - Accept bits; go PASS when the accept brings count to CRC_W.
  - recving=0: go DONE (short packet).
- PASS:
  - pause_in = pause_out; sending = recving; outb = delay[CRC_W-1], combinational from registers.
  - recving=1, pause_out=0: accept; oldest bit is consumed downstream the same cycle.
  - recving=1, pause_out=1: nothing shifts; outb, lfsr and delay line all hold.
  - recving=0: sending=0, go DONE. Delay contents (the received CRC) are never forwarded.
- DONE (exactly one cycle):
  - crc_valid=1; crc_ok = (lfsr==RESIDUAL) && (count==CRC_W).
  - pause_in=1, so a new packet starting this cycle is held, not lost.
  - Next cycle: lfsr=INIT, count=0, delay=0, state=IDLE.
- Latency:
  - First payload bit appears on outb on the cycle the (CRC_W+1)th bit is accepted.
  - crc_valid appears the cycle after recving falls.
- Packets shorter than CRC_W+1 bits:
  - No bits forwarded.
  - count<CRC_W: crc_ok=0.
  - count==CRC_W (zero-length payload): crc_ok follows the residual compare.
- pause_out is ignored outside PASS; no output is valid there.
- rst_L asserted mid-packet: immediate return to reset values. The partial packet produces no crc_valid.

Test Plan:
- No stalls: 16 bits = 11 zeros then 0,1,0,0,0 -> outb 11 zeros with sending high 11 cycles; final lfsr=01100; crc_valid 1 cycle with crc_ok=1.
- Same stream with last bit 1 -> 11 zeros forwarded; crc_valid with crc_ok=0.
- Stall: same stream, pause_out=1 for 3 cycles after the 3rd forwarded bit -> pause_in=1 for those 3 cycles; outb holds; 11 zeros forwarded, none duplicated or dropped; crc_ok=1.
- Short packet: 3 bits then recving=0 -> sending never asserted; crc_valid with crc_ok=0.
- Reset mid-packet: rst_L low after 8 bits -> all outputs 0 immediately, no crc_valid. Then a clean 16-bit stream -> crc_ok=1.
- Back-to-back: recving rises on the DONE cycle -> pause_in=1 that cycle, first bit accepted next cycle in IDLE; both packets report crc_ok=1.
